// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package pipe_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry-chunk of the pipelined adder: CW-bit add with registered sum, carry and valid.
module adder_stage #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          in_valid,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic          valid_reg,
    output logic [CW-1:0] sum_reg,
    output logic          cout_reg
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else if (en) begin
            valid_reg             <= in_valid;
            {cout_reg, sum_reg}   <= {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
        end
    end

endmodule

// File: rtl/pipe_adder_nb.sv
// Pipelined WIDTH-bit adder/subtractor, STAGES carry chunks, valid/ready on both sides.
// Define PIPE_ADD_OVF_EN to add the signed-overflow output Ovf.
module pipe_adder_nb
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = chunk_w(WIDTH, STAGES);

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipe_adder_nb: WIDTH must be a multiple of STAGES");
    end

    logic             stall;
    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic [STAGES:0]  carry;
    logic [STAGES:0]  vld;

    // The whole pipe moves in lockstep; it only freezes when a finished result is blocked.
    assign stall     = out_valid & ~out_ready;
    assign en        = ~stall;
    assign in_ready  = en;
    assign b_eff     = (sub == MODE_SUB) ? ~B : B;
    assign carry[0]  = (sub == MODE_ADD) ? Cin : 1'b1;
    assign vld[0]    = in_valid;
    assign out_valid = vld[STAGES];
    assign Cout      = carry[STAGES];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_chunk
        localparam int DESKEW = STAGES - 1 - gi;

        logic [CW-1:0] a_in;
        logic [CW-1:0] b_in;
        logic [CW-1:0] sum_reg;

        // Chunk gi waits gi cycles so it meets the carry rippling up from chunk gi-1.
        if (gi == 0) begin : g_noskew
            assign a_in = A[CW-1:0];
            assign b_in = b_eff[CW-1:0];
        end else begin : g_skew
            logic [CW-1:0] a_sk [1:gi];
            logic [CW-1:0] b_sk [1:gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 1; i <= gi; i++) begin
                        a_sk[i] <= '0;
                        b_sk[i] <= '0;
                    end
                end else if (en) begin
                    a_sk[1] <= A[gi*CW +: CW];
                    b_sk[1] <= b_eff[gi*CW +: CW];
                    for (int i = 2; i <= gi; i++) begin
                        a_sk[i] <= a_sk[i-1];
                        b_sk[i] <= b_sk[i-1];
                    end
                end
            end

            assign a_in = a_sk[gi];
            assign b_in = b_sk[gi];
        end

        adder_stage #(
            .CW(CW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (vld[gi]),
            .a         (a_in),
            .b         (b_in),
            .cin       (carry[gi]),
            .valid_reg (vld[gi+1]),
            .sum_reg   (sum_reg),
            .cout_reg  (carry[gi+1])
        );

        // Finished low chunks idle here until the top chunk catches up.
        if (DESKEW == 0) begin : g_nodeskew
            assign S[gi*CW +: CW] = sum_reg;
        end else begin : g_deskew
            logic [CW-1:0] s_dk [1:DESKEW];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 1; i <= DESKEW; i++) begin
                        s_dk[i] <= '0;
                    end
                end else if (en) begin
                    s_dk[1] <= sum_reg;
                    for (int i = 2; i <= DESKEW; i++) begin
                        s_dk[i] <= s_dk[i-1];
                    end
                end
            end

            assign S[gi*CW +: CW] = s_dk[DESKEW];
        end
    end

`ifdef PIPE_ADD_OVF_EN
    logic a_msb_reg;
    logic b_msb_reg;

    // Operand sign bits travel with the top chunk so Ovf lines up with S.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
        end else if (en) begin
            a_msb_reg <= g_chunk[STAGES-1].a_in[CW-1];
            b_msb_reg <= g_chunk[STAGES-1].b_in[CW-1];
        end
    end

    assign Ovf = (a_msb_reg == b_msb_reg) & (S[WIDTH-1] != a_msb_reg);
`endif

endmodule

// File: tb/tb_pipe_adder_nb.sv
// Self-checking bench for pipe_adder_nb (WIDTH=8, STAGES=2): vector table, scoreboard, stalls, reset.
module tb_pipe_adder_nb;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef PIPE_ADD_OVF_EN
    logic             ovf;
`endif

    pipe_adder_nb #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .sub       (sub_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s),
        .Cout      (cout)
`ifdef PIPE_ADD_OVF_EN
        ,
        .Ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    exp_t       cur_exp;
    logic       last_acc;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_s;
    logic       prev_c;
    vec_t       vt [13];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                   input logic ci, input logic sm);
        exp_t       e;
        logic [7:0] bb;
        logic [8:0] r;
        bb  = sm ? ~bv : bv;
        r   = {1'b0, av} + {1'b0, bb} + (sm ? 9'd1 : {8'd0, ci});
        e.s = r[7:0];
        e.c = r[8];
        e.o = (av[7] == bb[7]) && (r[7] != av[7]);
        return e;
    endfunction

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic sm, input logic rdy, input exp_t e);
        in_valid  = v;
        a         = av;
        b         = bv;
        cin       = ci;
        sub_i     = sm;
        out_ready = rdy;
        cur_exp   = e;
    endtask

    // Called just after a falling edge with inputs set; evaluates the handshakes of the coming rising edge.
    task automatic tick();
        #1;
        chk("in_ready_rule", in_ready, (out_valid && !out_ready) ? 0 : 1);
        if (prev_stall) begin
            chk("hold_S", s, prev_s);
            chk("hold_Cout", cout, prev_c);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got S=%0h, required no output", s);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result S=%02h Cout=%0d (required S=%02h Cout=%0d)", s, cout, e.s, e.c);
                chk("S", s, e.s);
                chk("Cout", cout, e.c);
`ifdef PIPE_ADD_OVF_EN
                chk("Ovf", ovf, e.o);
`endif
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) sb.push_back(cur_exp);
        prev_stall = out_valid && !out_ready;
        prev_s     = s;
        prev_c     = cout;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        exp_t z;
        z = '{8'h00, 1'b0, 1'b0};
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, z);
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, required finish within 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bp_a [3];
        logic [7:0] bp_b [3];
        int         issued;
        exp_t       z;

        vt[0]  = '{8'd200, 8'd100, 1'b1, 1'b0, 8'h2D, 1'b1, 1'b0};
        vt[1]  = '{8'd5,   8'd7,   1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vt[2]  = '{8'd127, 8'd1,   1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[3]  = '{8'h80,  8'd1,   1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vt[4]  = '{8'd3,   8'd4,   1'b0, 1'b0, 8'h07, 1'b0, 1'b0};
        vt[5]  = '{8'hFF,  8'h01,  1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[6]  = '{8'hFF,  8'h00,  1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[7]  = '{8'h00,  8'h00,  1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[8]  = '{8'h00,  8'h01,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vt[9]  = '{8'h0F,  8'h01,  1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vt[10] = '{8'hFF,  8'hFF,  1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vt[11] = '{8'h7F,  8'h80,  1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
        vt[12] = '{8'h80,  8'h80,  1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        bp_a = '{8'd10, 8'd20, 8'd30};
        bp_b = '{8'd1,  8'd2,  8'd3};
        z    = '{8'h00, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, z);
        @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_S", s, 0);
        chk("reset_Cout", cout, 0);
`ifdef PIPE_ADD_OVF_EN
        chk("reset_Ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Latency: exactly STAGES cycles from accept to out_valid
        drive(1'b1, vt[0].a, vt[0].b, vt[0].cin, vt[0].sub, 1'b1, '{vt[0].s, vt[0].c, vt[0].o});
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, z);
        chk("latency_cycle1", out_valid, 0);
        tick();
        chk("latency_cycle2", out_valid, 1);
        tick();

        // Vector table streamed back-to-back
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1'b1, '{vt[i].s, vt[i].c, vt[i].o});
            tick();
        end
        drain();

        // Backpressure: three ops offered while the consumer is stalled for four cycles
        issued = 0;
        for (int k = 0; k < 4; k++) begin
            drive(issued < 3, bp_a[issued % 3], bp_b[issued % 3], 1'b0, 1'b0, 1'b0,
                  model(bp_a[issued % 3], bp_b[issued % 3], 1'b0, 1'b0));
            tick();
            if (last_acc) issued++;
        end
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_accepted_before_release", issued, 2);
        for (int k = 0; k < 20 && issued < 3; k++) begin
            drive(1'b1, bp_a[issued], bp_b[issued], 1'b0, 1'b0, 1'b1,
                  model(bp_a[issued], bp_b[issued], 1'b0, 1'b0));
            tick();
            if (last_acc) issued++;
        end
        chk("bp_all_issued", issued, 3);
        drain();

        // Reset with two ops in flight
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, model(8'h12, 8'h34, 1'b0, 1'b0));
        tick();
        drive(1'b1, 8'h56, 8'h11, 1'b0, 1'b1, 1'b1, model(8'h56, 8'h11, 1'b0, 1'b1));
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, z);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_S", s, 0);
        chk("midrst_Cout", cout, 0);
        sb.delete();
        prev_stall = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("no_stale_output", out_valid, 0);
            tick();
        end

        // Random stream with random backpressure against the behavioural model
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] av;
            logic [7:0] bv;
            logic       ci;
            logic       sm;
            av = 8'($urandom);
            bv = 8'($urandom);
            ci = 1'($urandom);
            sm = 1'($urandom);
            drive($urandom_range(0, 3) != 0, av, bv, ci, sm, $urandom_range(0, 9) < 7,
                  model(av, bv, ci, sm));
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
